// File: rtl/geo_pkg.sv
// Shared types and constants for the geometry command feeder.
package geo_pkg;

    localparam int GEO_CMD_W = 16;

    // Drain FSM: IDLE waits for data and a free consumer, ISSUE presents one
    // word, HOLD gives the consumer one clock to raise its busy flag.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/geo_cmd_fifo_ram.sv
// Dual-port command storage with a registered read port (block-RAM style).
// The read register is only loaded when rd_en is high. It therefore doubles
// as the stable command output register of the feeder.
module geo_cmd_fifo_ram
    import geo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [GEO_CMD_W-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [GEO_CMD_W-1:0] rd_data
);

    logic [GEO_CMD_W-1:0] mem [DEPTH];

    // Write port.
    // NOTE: the array has no reset so it can map onto block RAM; stale words
    // are unreachable because the feeder resets its pointers instead.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses <= so every register samples
        // pre-edge values, independent of block ordering.
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value between reads, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/geo_cmd_feeder.sv
// Z80-facing command FIFO feeding the geometry processor.
// Two byte-wide port writes build one 16-bit word (high byte latched first,
// low byte commits). A three-state drain FSM hands one word per strobe to the
// geometry processor, honouring its busy flag.
module geo_cmd_feeder
    import geo_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_hi_stb,
    input  logic                 wr_lo_stb,
    input  logic [7:0]           bus_data,
    input  logic                 geo_busy,
    input  logic                 ovf_clr,
    output logic [GEO_CMD_W-1:0] fifo_cmd_in,
    output logic                 fifo_cmd_ready,
    output logic [LVL_W-1:0]     level,
    output logic                 full,
    output logic                 overflow
);

    localparam int ADDR_W = LVL_W - 1;

    drain_state_t     state;
    logic [7:0]       hi_latch;
    logic [LVL_W-1:0] wr_cnt;
    logic [LVL_W-1:0] rd_cnt;
    logic             push;
    logic             pop;
    logic             drop;
    logic             issue_go;

    // Occupancy is the difference of free-running counts one bit wider than
    // the address, so full and empty are distinguishable.
    assign level = wr_cnt - rd_cnt;
    assign full  = (level == LVL_W'(FIFO_DEPTH));

    // Push/pop/drop decisions; a pop in ISSUE frees a slot for a same-clock push.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        push     = 1'b0;
        drop     = 1'b0;
        pop      = (state == ISSUE);
        issue_go = (state == IDLE) && (level != '0) && !geo_busy;
        if (wr_lo_stb) begin
            if (!full || pop) begin
                push = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // High-byte latch; a same-clock commit still sees the previous value.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_latch <= 8'h00;
        end else if (wr_hi_stb) begin
            hi_latch <= bus_data;
        end
    end

    // Write and read counters; their low bits are the RAM pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (push) begin
                wr_cnt <= wr_cnt + LVL_W'(1);
            end
            if (pop) begin
                rd_cnt <= rd_cnt + LVL_W'(1);
            end
        end
    end

    // Sticky overflow; a dropped commit beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Drain FSM with registered strobe: IDLE -> ISSUE -> HOLD -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            fifo_cmd_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_go) begin
                        state          <= ISSUE;
                        fifo_cmd_ready <= 1'b1;
                    end else begin
                        fifo_cmd_ready <= 1'b0;
                    end
                end
                ISSUE: begin
                    state          <= HOLD;
                    fifo_cmd_ready <= 1'b0;
                end
                HOLD: begin
                    state          <= IDLE;
                    fifo_cmd_ready <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    fifo_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    // The head word is read on the IDLE->ISSUE edge. The RAM read register is
    // then the command output and stays stable until the next issue.
    geo_cmd_fifo_ram #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push && !reset),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_data ({hi_latch, bus_data}),
        .rd_en   (issue_go),
        .rd_addr (rd_cnt[ADDR_W-1:0]),
        .rd_data (fifo_cmd_in)
    );

endmodule

// File: tb/tb_geo_cmd_feeder.sv
// Scoreboard bench for geo_cmd_feeder: stimulus pushes expected words, a
// negedge monitor pops and compares on every fifo_cmd_ready strobe.
module tb_geo_cmd_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_hi_stb = 1'b0;
    logic        wr_lo_stb = 1'b0;
    logic [7:0]  bus_data = 8'h00;
    logic        geo_busy = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [15:0] fifo_cmd_in;
    logic        fifo_cmd_ready;
    logic [4:0]  level;
    logic        full;
    logic        overflow;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;
    int          last_rdy = -100;
    logic [15:0] exp_q [$];
    int          stamps [$];

    geo_cmd_feeder #(.FIFO_DEPTH(16), .LVL_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_hi_stb      (wr_hi_stb),
        .wr_lo_stb      (wr_lo_stb),
        .bus_data       (bus_data),
        .geo_busy       (geo_busy),
        .ovf_clr        (ovf_clr),
        .fifo_cmd_in    (fifo_cmd_in),
        .fifo_cmd_ready (fifo_cmd_ready),
        .level          (level),
        .full           (full),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Monitor: every strobe must match the oldest expected word and be at
    // least 3 clocks after the previous one.
    always @(negedge clk) begin
        if (fifo_cmd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: got word %h expected no strobe (cycle %0d)",
                         fifo_cmd_in, cyc_cnt);
            end else begin
                check("cmd_word", {16'h0, fifo_cmd_in}, {16'h0, exp_q.pop_front()});
            end
            check("ready_gap_ge3", {31'h0, (cyc_cnt - last_rdy) >= 3}, 32'h1);
            last_rdy = cyc_cnt;
            stamps.push_back(cyc_cnt);
        end
    end

    // One clock of strobes, applied just after a rising edge.
    task automatic drive(input logic hi, input logic lo, input logic [7:0] d, input logic clr);
        wr_hi_stb = hi;
        wr_lo_stb = lo;
        bus_data  = d;
        ovf_clr   = clr;
        @(posedge clk);
        #1;
        wr_hi_stb = 1'b0;
        wr_lo_stb = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for the scoreboard to empty.
    task automatic wait_drain(input string name);
        int budget;
        budget = 300;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        idle(3);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ready", fifo_cmd_ready, 0);
        check("rst_cmd_in", fifo_cmd_in, 16'h0000);
        idle(1);

        // Single word, two-clock latency
        drive(1'b1, 1'b0, 8'h12, 1'b0);
        exp_q.push_back(16'h1234);
        drive(1'b0, 1'b1, 8'h34, 1'b0);
        @(negedge clk);
        check("lat_ready_early", fifo_cmd_ready, 0);
        @(negedge clk);
        check("lat_ready_at2", fifo_cmd_ready, 1);
        check("lat_word", fifo_cmd_in, 16'h1234);
        wait_drain("t1");
        check("t1_level", level, 0);

        // Fill while busy, overflow, clear priority, then drain rate
        geo_busy = 1'b1;
        drive(1'b1, 1'b0, 8'h01, 1'b0);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({8'h01, 8'(i)});
            drive(1'b0, 1'b1, 8'(i), 1'b0);
        end
        check("fill_level_pre", level, 16);
        check("fill_ovf_pre", overflow, 0);
        drive(1'b0, 1'b1, 8'hFF, 1'b0);
        check("fill_full", full, 1);
        check("fill_level", level, 16);
        check("fill_ovf", overflow, 1);
        drive(1'b0, 1'b1, 8'hFE, 1'b1);
        check("ovf_set_wins", overflow, 1);
        check("ovf_level_kept", level, 16);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_cleared", overflow, 0);
        stamps.delete();
        geo_busy = 1'b0;
        wait_drain("t2");
        check("t2_strobe_count", stamps.size(), 16);
        if (stamps.size() == 16) check("t2_span_3clk", stamps[15] - stamps[0], 45);
        check("t2_level", level, 0);

        // Simultaneous hi/lo uses old latch, then latch holds new byte
        drive(1'b1, 1'b0, 8'hAA, 1'b0);
        exp_q.push_back(16'hAA55);
        drive(1'b1, 1'b1, 8'h55, 1'b0);
        idle(3);
        exp_q.push_back(16'h5501);
        drive(1'b0, 1'b1, 8'h01, 1'b0);
        wait_drain("t3");

        // Push into a full FIFO on the pop clock
        geo_busy = 1'b1;
        drive(1'b1, 1'b0, 8'h02, 1'b0);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({8'h02, 8'(i)});
            drive(1'b0, 1'b1, 8'(i), 1'b0);
        end
        check("t4_full", full, 1);
        geo_busy = 1'b0;
        idle(1);
        check("t4_in_issue", fifo_cmd_ready, 1);
        exp_q.push_back(16'h02EE);
        drive(1'b0, 1'b1, 8'hEE, 1'b0);
        check("t4_level_same", level, 16);
        check("t4_ovf_clear", overflow, 0);
        wait_drain("t4");

        // Reset during ISSUE drops the queue and the in-flight word
        geo_busy = 1'b1;
        drive(1'b1, 1'b0, 8'h03, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({8'h03, 8'(i)});
            drive(1'b0, 1'b1, 8'(i), 1'b0);
        end
        geo_busy = 1'b0;
        idle(1);
        check("t5_in_issue", fifo_cmd_ready, 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_ready", fifo_cmd_ready, 0);
            check("t5_level", level, 0);
            check("t5_cmd_in", fifo_cmd_in, 16'h0000);
        end
        idle(1);

        // High latch back to 0x00 after reset
        exp_q.push_back(16'h0077);
        drive(1'b0, 1'b1, 8'h77, 1'b0);
        wait_drain("t6");
        check("end_level", level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
